intr_ctrl: RTL



---
 rtl/intr_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: collects per-source interrupt pulses into pending bits and masks
// them with a software enable register. The lowest eligible index wins and is
// presented to the core on a single irq line. A claim/complete handshake keeps
// exactly one source in service at a time.
module intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_pulse,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] enable,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               irq,
  input  logic               claim_req,
  output logic               claim_ack,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               cmpl_valid,
  input  logic [ID_W-1:0]    cmpl_id,
  output logic               cmpl_err,
  output logic [ID_W-1:0]    active_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic               irq_q, irq_d;
  logic               claim_ack_q, claim_ack_d;
  logic               claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               cmpl_err_q, cmpl_err_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;

  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic               grant;
  logic               cmpl_match;
  logic [NUM_SRC-1:0] grant_mask;

  assign eligible   = pending_q & enable_q;
  assign grant      = (state_q == PEND) && claim_req && (|eligible);
  assign cmpl_match = (state_q == ACTIVE) && cmpl_valid && (cmpl_id == active_id_q);
  assign grant_mask = grant ? (NUM_SRC'(1) << winner) : '0;

  // Fixed priority: scan from the top so the lowest set index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // Next-state logic for the service FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|eligible) state_d = PEND;
      PEND: begin
        if (!(|eligible))  state_d = IDLE;
        else if (claim_req) state_d = ACTIVE;
      end
      ACTIVE:  if (cmpl_match) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file and handshake next-state values.
  always_comb begin
    enable_d      = cfg_we ? cfg_wdata : enable_q;
    // A pulse arriving in the grant cycle is a fresh event: it re-arms pending
    // but is not counted as an overrun of the event being claimed.
    pending_d     = (pending_q & ~grant_mask) | src_pulse;
    overrun_d     = (overrun_q | (src_pulse & pending_q)) & ~grant_mask;
    irq_d         = (state_d == PEND);
    claim_ack_d   = claim_req;
    claim_valid_d = grant;
    claim_id_d    = grant ? winner : '0;
    active_id_d   = grant ? winner : active_id_q;
    cmpl_err_d    = cmpl_valid && !cmpl_match;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      enable_q      <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      irq_q         <= 1'b0;
      claim_ack_q   <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      cmpl_err_q    <= 1'b0;
      active_id_q   <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      irq_q         <= irq_d;
      claim_ack_q   <= claim_ack_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      cmpl_err_q    <= cmpl_err_d;
      active_id_q   <= active_id_d;
    end
  end

  assign enable      = enable_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign irq         = irq_q;
  assign claim_ack   = claim_ack_q;
  assign claim_valid = claim_valid_q;
  assign claim_id    = claim_id_q;
  assign cmpl_err    = cmpl_err_q;
  assign active_id   = active_id_q;

endmodule
